commit_unit: RTL
================

Name: commit_unit

Overview:
- Consumer end of the reorder buffer's commit interface; sits between the ROB head and the architectural state.
- Per committed instruction it:
  - drives the register-file write port;
  - pushes stores into a post-commit store buffer, which drains to data memory over a req/gnt handshake;
  - issues a registered front-end redirect on committed taken branches;
  - maintains the retired-instruction counter.
- The ROB has no backpressure, so this block accepts one commit per cycle unconditionally.

Parameters:
- SB_DEPTH, 4, store buffer entries; power of two, ≥2.
- INSTRET_W, 64, width of retired-instruction counter.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- commit_valid_i  in  1  ROB head retires this cycle
- commit_pc_i  in  32  PC of retiring instruction
- commit_instr_i  in  32 (instruction_t)  retiring instruction
- commit_rd_addr_i  in  5 (reg_addr_t)  destination register
- commit_result_i  in  32  ALU result; effective address for stores
- commit_write_enable_i  in  1  instruction writes rd
- commit_store_to_mem_i  in  1  instruction is a store
- commit_new_pc_i  in  32  branch target; store data for stores
- commit_branch_taken_i  in  1  taken branch/jump
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- redirect_valid_o  out  1  front-end redirect pulse
- redirect_pc_o  out  32  redirect target
- dmem_req_o  out  1  store request
- dmem_addr_o  out  32  word-aligned address
- dmem_wdata_o  out  32  lane-aligned data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  memory accepts request this cycle
- sb_full_o  out  1  store buffer holds SB_DEPTH entries
- sb_empty_o  out  1  store buffer empty
- sb_overflow_o  out  1  sticky overflow error
- instret_o  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset values:
  - all outputs 0, except sb_empty_o = 1;
  - pointers and count 0; FSM in IDLE; all entries invalid.
- Register-file write (combinational, same cycle as commit):
  - rf_we_o = commit_valid_i & commit_write_enable_i & (rd != 0);
  - rf_waddr_o = rd; rf_wdata_o = result.
  - rf_waddr_o and rf_wdata_o are 0 when rf_we_o is 0.
- Retired counter: instret increments on every commit_valid_i; wraps modulo 2^INSTRET_W.
- Redirect (registered):
  - A commit with branch_taken = 1 gives redirect_valid_o = 1 for exactly the next cycle, with redirect_pc_o = commit_new_pc_i.
  - Otherwise redirect_valid_o = 0 and redirect_pc_o holds its last value.
- Store enqueue, on commit_valid_i & store_to_mem_i:
  - funct3 = instr[14:12]; off = result[1:0].
  - SB: be = 1 << off; data = new_pc[7:0] << 8*off.
  - SH: be = 4'b0011 << off; data = new_pc[15:0] << 8*off.
  - SW: be = 4'b1111; data = new_pc.
  - Entry address = {result[31:2], 2'b00}.
  - Misalignment is not checked; shifted lanes above bit 3 are truncated.
- Drain FSM:
  - IDLE → REQ when count != 0.
  - In REQ: dmem_req_o = 1 with addr, data and be of the head entry, held stable until dmem_gnt_i.
  - On gnt: pop the head. Stay in REQ if count after the pop is nonzero, else go to IDLE.
  - First request appears the cycle after enqueue; there is no same-cycle bypass.
  - dmem_gnt_i is ignored while dmem_req_o is 0.
- Boundaries:
  - Simultaneous enqueue and pop: count unchanged, both pointers advance, wrap modulo SB_DEPTH.
  - Enqueue while full with no pop in the same cycle: the store is dropped, sb_overflow_o is set and stays set until reset, buffer unchanged.
  - Enqueue while full with a pop in the same cycle: the store is accepted.
  - Committed taken branches never flush the store buffer; committed stores are architectural.
  - Reset mid-drain: request dropped immediately (asynchronous), buffer emptied.
- The decode stage stalls stores using sb_full_o; this block does not backpressure the ROB.

Optional Feature:
- Macro: TARTARUGA_SB_FWD_EN.
- With the macro defined, the block adds these ports:
  - ld_addr_i (32), input;
  - fwd_hit_o (1), output;
  - fwd_data_o (32), output;
  - fwd_be_o (4), output.
- Forwarding lookup, combinational:
  - search from newest to oldest valid entry whose word address matches ld_addr_i[31:2];
  - on the first match, return its data and be;
  - fwd_hit_o = 1 on a match;
  - no merging across entries.
- Without the macro: the ports are absent and no lookup logic is built.

Decomposition:
- tartaruga_pkg gets:
  - sb_entry_t {addr, data, be};
  - sb_idx_t;
  - parameter SB_DEPTH_DEFAULT;
  - commit_drain_state_t {IDLE, REQ};
  - constants FUNCT3_SB = 3'b000, FUNCT3_SH = 3'b001, FUNCT3_SW = 3'b010.
- One sub-module, store_buffer: FIFO storage, drain FSM and the forwarding lookup.
- commit_unit keeps register-file write, redirect, instret and lane formation.

Test Plan:
- SW commit, addr 0x100, data 0xDEADBEEF, gnt held low 3 cycles → dmem_req_o rises the next cycle with addr 0x100, be 1111, stable for 3 cycles; pops on gnt; sb_empty_o = 1 the cycle after.
- SB commit, addr 0x103, data 0x000000AB → dmem_addr_o 0x100, be 1000, wdata 0xAB000000. SH at addr 0x102, data 0x1234 → be 1100, wdata 0x12340000.
- Four stores committed with gnt = 0 → sb_full_o = 1. Fifth store → sb_overflow_o = 1 and the drain order is unchanged. After reset, full plus a store in the same cycle as gnt → accepted, no overflow.
- Taken branch committed with new_pc 0x80 → redirect_valid_o = 1 for exactly one cycle, starting the next cycle, with redirect_pc_o = 0x80. Back-to-back taken commits → two consecutive pulses.
- ADD with rd = x5, result 7 → rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 7 in the same cycle. rd = x0 → rf_we_o = 0. instret_o counts 2 after both commits.
- Reset asserted while in REQ with 3 entries → dmem_req_o = 0 immediately, sb_empty_o = 1. With TARTARUGA_SB_FWD_EN, two stores to 0x200 → load 0x200 returns the newer entry's data.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the commit path and its post-commit store buffer.
package tartaruga_pkg;

  parameter int SB_DEPTH_DEFAULT = 4;

  typedef logic [31:0] instruction_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [$clog2(SB_DEPTH_DEFAULT)-1:0] sb_idx_t;

  // One buffered store: word-aligned address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } commit_drain_state_t;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

endpackage

// File: rtl/store_buffer.sv
// Post-commit store FIFO with a req/gnt drain engine.
// With TARTARUGA_SB_FWD_EN defined, a newest-first load forwarding lookup is built.
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enq_valid,
  input  sb_entry_t   enq_entry,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  output logic        full,
  output logic        empty,
  output logic        overflow
`ifdef TARTARUGA_SB_FWD_EN
  ,
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_be
`endif
);

  localparam int IW = $clog2(SB_DEPTH);
  localparam logic [IW:0] DEPTH_C = (IW+1)'(SB_DEPTH);

  sb_entry_t           mem [SB_DEPTH];
  logic [IW-1:0]       wr_ptr, rd_ptr;
  logic [IW:0]         count, count_nxt;
  commit_drain_state_t state, state_nxt;
  logic                pop, push;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a store arriving while full is still accepted.
  assign pop  = (state == REQ) & dmem_gnt;
  assign push = enq_valid & (~full | pop);

  assign count_nxt = count + (IW+1)'(push) - (IW+1)'(pop);

  // Drain FSM: look at the post-update occupancy so a request shows up one cycle after enqueue.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count_nxt != '0) state_nxt = REQ;
      REQ:     if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointers, occupancy, FSM and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= IDLE;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      state <= state_nxt;
      if (enq_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // Entry storage; a dropped store leaves the array untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SB_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // Head entry is presented only while requesting so the bus idles at zero.
  assign dmem_req   = (state == REQ);
  assign dmem_addr  = dmem_req ? mem[rd_ptr].addr : '0;
  assign dmem_wdata = dmem_req ? mem[rd_ptr].data : '0;
  assign dmem_be    = dmem_req ? mem[rd_ptr].be   : '0;

`ifdef TARTARUGA_SB_FWD_EN
  logic [SB_DEPTH-1:0] vld;

  // Per-entry valid bits, needed only to qualify forwarding matches.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld <= '0;
    end else begin
      if (pop)  vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end

  // Walk oldest to newest so the last match (the newest store) wins; no byte merging.
  always_comb begin
    logic [IW-1:0] k;
    k        = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_be   = '0;
    for (int i = SB_DEPTH; i >= 1; i--) begin
      k = wr_ptr - IW'(i);
      if (vld[k] && mem[k].addr[31:2] == ld_addr[31:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[k].data;
        fwd_be   = mem[k].be;
      end
    end
  end
`endif

endmodule

// File: rtl/commit_unit.sv
// ROB commit consumer: register-file write, taken-branch redirect, retired counter,
// and store lane formation feeding the post-commit store buffer.
// Optional load forwarding from the store buffer: define TARTARUGA_SB_FWD_EN.
module commit_unit
  import tartaruga_pkg::*;
#(
  parameter int SB_DEPTH  = SB_DEPTH_DEFAULT,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 commit_valid_i,
  input  logic [31:0]          commit_pc_i,
  input  instruction_t         commit_instr_i,
  input  reg_addr_t            commit_rd_addr_i,
  input  logic [31:0]          commit_result_i,
  input  logic                 commit_write_enable_i,
  input  logic                 commit_store_to_mem_i,
  input  logic [31:0]          commit_new_pc_i,
  input  logic                 commit_branch_taken_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 redirect_valid_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 dmem_req_o,
  output logic [31:0]          dmem_addr_o,
  output logic [31:0]          dmem_wdata_o,
  output logic [3:0]           dmem_be_o,
  input  logic                 dmem_gnt_i,
  output logic                 sb_full_o,
  output logic                 sb_empty_o,
  output logic                 sb_overflow_o,
  output logic [INSTRET_W-1:0] instret_o
`ifdef TARTARUGA_SB_FWD_EN
  ,
  input  logic [31:0]          ld_addr_i,
  output logic                 fwd_hit_o,
  output logic [31:0]          fwd_data_o,
  output logic [3:0]           fwd_be_o
`endif
);

  sb_entry_t  enq_entry;
  logic [2:0] funct3;
  logic [1:0] off;

  // The commit PC and non-funct3 instruction bits carry no work here.
  logic unused_bits;
  assign unused_bits = ^{commit_pc_i, commit_instr_i[31:15], commit_instr_i[11:0]};

  // Register-file write happens in the commit cycle; x0 writes are suppressed.
  assign rf_we_o    = commit_valid_i & commit_write_enable_i & (commit_rd_addr_i != '0);
  assign rf_waddr_o = rf_we_o ? commit_rd_addr_i : '0;
  assign rf_wdata_o = rf_we_o ? commit_result_i  : '0;

  // One-cycle redirect pulse; the target register keeps the last taken target.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= commit_valid_i & commit_branch_taken_i;
      if (commit_valid_i && commit_branch_taken_i) redirect_pc_o <= commit_new_pc_i;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) instret_o <= '0;
    else if (commit_valid_i) instret_o <= instret_o + INSTRET_W'(1);
  end

  assign funct3 = commit_instr_i[14:12];
  assign off    = commit_result_i[1:0];

  // Lane formation: shift byte/half into its lane; lanes past byte 3 fall off the top.
  always_comb begin
    enq_entry      = '0;
    enq_entry.addr = {commit_result_i[31:2], 2'b00};
    case (funct3)
      FUNCT3_SB: begin
        enq_entry.be   = 4'b0001 << off;
        enq_entry.data = {24'b0, commit_new_pc_i[7:0]} << {off, 3'b000};
      end
      FUNCT3_SH: begin
        enq_entry.be   = 4'b0011 << off;
        enq_entry.data = {16'b0, commit_new_pc_i[15:0]} << {off, 3'b000};
      end
      default: begin
        enq_entry.be   = 4'b1111;
        enq_entry.data = commit_new_pc_i;
      end
    endcase
  end

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .enq_valid  (commit_valid_i & commit_store_to_mem_i),
    .enq_entry  (enq_entry),
    .dmem_req   (dmem_req_o),
    .dmem_addr  (dmem_addr_o),
    .dmem_wdata (dmem_wdata_o),
    .dmem_be    (dmem_be_o),
    .dmem_gnt   (dmem_gnt_i),
    .full       (sb_full_o),
    .empty      (sb_empty_o),
    .overflow   (sb_overflow_o)
`ifdef TARTARUGA_SB_FWD_EN
    ,
    .ld_addr    (ld_addr_i),
    .fwd_hit    (fwd_hit_o),
    .fwd_data   (fwd_data_o),
    .fwd_be     (fwd_be_o)
`endif
  );

endmodule
